// File: rtl/multicycle_arith_unit.sv
// Multicycle arithmetic unit: GCD, shift-add MUL, restoring DIV/MOD, LFSR RAND.
// One shared three-register datapath iterated by an IDLE/RUN/DONE controller.
module multicycle_arith_unit #(
  parameter int          WIDTH     = 8,
  parameter int unsigned LFSR_SEED = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic [2:0]       flags
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] SEED = WIDTH'(LFSR_SEED);

  function automatic logic [WIDTH-1:0] tap_mask();
    logic [31:0] m;
    case (WIDTH)
      4:       m = 32'h9;
      5:       m = 32'h12;
      6:       m = 32'h21;
      7:       m = 32'h41;
      8:       m = 32'hB8;
      9:       m = 32'h108;
      10:      m = 32'h204;
      11:      m = 32'h402;
      12:      m = 32'h829;
      13:      m = 32'h100D;
      14:      m = 32'h2015;
      15:      m = 32'h4001;
      16:      m = 32'h8016;
      17:      m = 32'h10004;
      18:      m = 32'h20013;
      19:      m = 32'h40013;
      20:      m = 32'h80004;
      21:      m = 32'h100002;
      22:      m = 32'h200001;
      23:      m = 32'h400010;
      24:      m = 32'h80000D;
      25:      m = 32'h1000004;
      26:      m = 32'h2000023;
      27:      m = 32'h4000013;
      28:      m = 32'h8000004;
      29:      m = 32'h10000002;
      30:      m = 32'h20000029;
      31:      m = 32'h40000004;
      default: m = 32'h80000057;
    endcase
    return m[WIDTH-1:0];
  endfunction

  localparam logic [WIDTH-1:0] TAPS = tap_mask();

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [2:0] {
    K_ILL, K_GCD, K_MUL, K_DIV, K_MOD, K_RAND
  } kind_t;

  state_t           state_q, state_d;
  kind_t            kind_q, kind_d;
  logic             fin_q, fin_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [2:0]       flags_q, flags_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic             gcd_stop;
  logic             quick;
  logic [WIDTH-1:0] f_res;
  logic [WIDTH-1:0] f_rem;
  logic             f_err;
  logic             f_ovf;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, x_q} : '0);
    div_sh   = {hi_q, lo_q[WIDTH-1]};
    div_ge   = div_sh >= {1'b0, x_q};
    div_diff = div_sh[WIDTH-1:0] - x_q;
    gcd_stop = (hi_q == lo_q) || (hi_q == '0) || (lo_q == '0);
    quick    = (kind_q == K_ILL) ||
               ((kind_q inside {K_DIV, K_MOD, K_RAND}) && x_q == '0);
  end

  // Final values read straight off the datapath once iteration ends
  always_comb begin
    f_res = '0;
    f_rem = '0;
    f_err = 1'b0;
    f_ovf = 1'b0;
    case (kind_q)
      K_GCD:  f_res = (hi_q == '0) ? lo_q : hi_q;
      K_MUL: begin
        f_res = lo_q;
        f_ovf = |hi_q;
      end
      K_DIV: begin
        f_err = (x_q == '0);
        f_res = f_err ? '1 : lo_q;
        f_rem = f_err ? lo_q : hi_q;
      end
      K_MOD: begin
        f_err = (x_q == '0);
        f_res = f_err ? lo_q : hi_q;
        f_rem = f_err ? lo_q : hi_q;
      end
      K_RAND: f_res = (x_q == '0) ? lo_q : hi_q;
      default: f_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    fin_d    = fin_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    lfsr_d   = lfsr_q;
    result_d = result_q;
    rem_d    = rem_q;
    flags_d  = flags_q;
    busy_d   = busy_q;
    done_d   = done_q;
    if (run) begin
      lfsr_d = {1'b0, lfsr_q[WIDTH-1:1]} ^ (lfsr_q[0] ? TAPS : '0);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_RUN;
            busy_d  = 1'b1;
            fin_d   = 1'b0;
            cnt_d   = '0;
            hi_d    = '0;
            x_d     = operand_b;
            lo_d    = operand_a;
            case (opcode)
              4'b0001: begin
                kind_d = K_GCD;
                hi_d   = operand_a;
                lo_d   = operand_b;
                x_d    = '0;
              end
              4'b0010: begin
                kind_d = K_MUL;
                x_d    = operand_a;
                lo_d   = operand_b;
              end
              4'b0011: kind_d = K_DIV;
              4'b0100: kind_d = K_MOD;
              4'b0101: begin
                kind_d = K_RAND;
                lo_d   = lfsr_q;
              end
              default: begin
                kind_d = K_ILL;
                x_d    = '0;
                lo_d   = '0;
              end
            endcase
          end
        end
        S_RUN: begin
          if (fin_q) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = f_res;
            rem_d    = f_rem;
            flags_d  = {f_err, f_ovf, f_res == '0};
          end else if (quick) begin
            fin_d = 1'b1;
          end else begin
            case (kind_q)
              K_GCD: begin
                if (gcd_stop) fin_d = 1'b1;
                else if (hi_q > lo_q) hi_d = hi_q - lo_q;
                else lo_d = lo_q - hi_q;
              end
              K_MUL: begin
                hi_d  = mul_sum[WIDTH:1];
                lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                fin_d = (cnt_q == CW'(WIDTH - 1));
              end
              default: begin
                hi_d  = div_ge ? div_diff : div_sh[WIDTH-1:0];
                lo_d  = {lo_q[WIDTH-2:0], div_ge};
                cnt_d = cnt_q + CW'(1);
                fin_d = (cnt_q == CW'(WIDTH - 1));
              end
            endcase
          end
        end
        default: begin
          state_d = S_IDLE;
          done_d  = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      kind_q   <= K_ILL;
      fin_q    <= 1'b0;
      cnt_q    <= '0;
      x_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      lfsr_q   <= SEED;
      result_q <= '0;
      rem_q    <= '0;
      flags_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      fin_q    <= fin_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      lfsr_q   <= lfsr_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      flags_q  <= flags_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign remainder = rem_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_multicycle_arith_unit.sv
// Bench for multicycle_arith_unit: vector table, random ops against an
// arithmetic reference model, and hand-written stall/abort sequences.
module tb_multicycle_arith_unit;

  localparam int W = 8;
  localparam int MASK = (1 << W) - 1;

  logic         clock = 1'b0;
  logic         reset;
  logic         run;
  logic         start;
  logic [3:0]   opcode;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] remainder;
  logic [2:0]   flags;

  multicycle_arith_unit #(.WIDTH(W), .LFSR_SEED(1)) dut (
    .clock(clock), .reset(reset), .run(run), .start(start),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .result(result),
    .remainder(remainder), .flags(flags)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Maximal-length sequence, indexed by run-enabled edges since reset
  int seq[255];
  int k;

  always @(posedge clock or posedge reset)
    if (reset) k <= 0;
    else if (run) k <= (k + 1) % 255;

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  function automatic void model(input logic [3:0] op, input int a, b, cap,
                                output int res, rem, flg, lat);
    int x, y, n, err, ovf;
    res = 0; rem = 0; err = 0; ovf = 0; lat = W + 1;
    case (op)
      4'd1: begin
        x = a; y = b; n = 0;
        while (x != y && x != 0 && y != 0) begin
          if (x > y) x -= y; else y -= x;
          n++;
        end
        res = (x == 0) ? y : x;
        lat = n + 2;
      end
      4'd2: begin
        res = (a * b) & MASK;
        ovf = ((a * b) > MASK) ? 1 : 0;
      end
      4'd3, 4'd4: begin
        if (b == 0) begin
          res = (op == 4'd3) ? MASK : a;
          rem = a; err = 1; lat = 2;
        end else begin
          res = (op == 4'd3) ? a / b : a % b;
          rem = a % b;
        end
      end
      4'd5: begin
        if (b == 0) begin res = cap; lat = 2; end
        else res = cap % b;
      end
      default: begin err = 1; lat = 2; end
    endcase
    flg = err * 4 + ovf * 2 + ((res == 0) ? 1 : 0);
  endfunction

  task automatic run_op(input logic [3:0] op, input int a, b,
                        input string nm, input int hold_at, hold_len,
                        input bit poke);
    int res, rem, flg, lat, got_lat, cap;
    bit seen;
    @(negedge clock);
    opcode = op; operand_a = W'(a); operand_b = W'(b); start = 1'b1;
    cap = seq[k];
    model(op, a, b, cap, res, rem, flg, lat);
    lat += hold_len;
    @(posedge clock); #1;
    start = 1'b0;
    operand_a = W'($urandom); operand_b = W'($urandom);
    opcode = 4'($urandom);
    got_lat = 0; seen = 1'b0;
    while (!seen && got_lat < 600) begin
      start = (poke && got_lat == 2);
      @(posedge clock); #1;
      got_lat++;
      if (hold_len > 0 && got_lat == hold_at) begin
        run = 1'b0;
        repeat (hold_len) begin @(posedge clock); #1; got_lat++; end
        chk({nm, "_hold_done"}, int'(done), 0);
        chk({nm, "_hold_busy"}, int'(busy), 1);
        run = 1'b1;
      end
      seen = done;
    end
    start = 1'b0;
    chk({nm, "_lat"}, got_lat, lat);
    chk({nm, "_res"}, int'(result), res);
    chk({nm, "_rem"}, int'(remainder), rem);
    chk({nm, "_flags"}, int'(flags), flg);
    chk({nm, "_busy"}, int'(busy), 1);
    @(posedge clock); #1;
    chk({nm, "_idle"}, int'({busy, done}), 0);
    if (poke) begin
      @(posedge clock); #1;
      chk({nm, "_noqueue"}, int'(busy), 0);
    end
  endtask

  typedef struct {
    logic [3:0] op;
    int a, b;
    int res, rem, flg, lat;
  } vec_t;

  vec_t vt[14];

  initial begin
    int s, ill[10], op, a, b, t;
    s = 1;
    for (int i = 0; i < 255; i++) begin
      seq[i] = s;
      s = (s >> 1) ^ (((s & 1) != 0) ? 'hB8 : 0);
    end
    ill = '{0, 6, 7, 8, 9, 10, 11, 12, 13, 15};

    vt[0]  = '{4'd2, 13, 11, 143, 0, 0, 9};
    vt[1]  = '{4'd2, 20, 20, 144, 0, 2, 9};
    vt[2]  = '{4'd3, 200, 7, 28, 4, 0, 9};
    vt[3]  = '{4'd4, 200, 7, 4, 4, 0, 9};
    vt[4]  = '{4'd3, 200, 0, 255, 200, 4, 2};
    vt[5]  = '{4'd4, 200, 0, 200, 200, 4, 2};
    vt[6]  = '{4'd1, 48, 18, 6, 0, 0, 6};
    vt[7]  = '{4'd1, 0, 0, 0, 0, 1, 2};
    vt[8]  = '{4'd1, 0, 9, 9, 0, 0, 2};
    vt[9]  = '{4'd0, 5, 5, 0, 0, 5, 2};
    vt[10] = '{4'hF, 1, 2, 0, 0, 5, 2};
    vt[11] = '{4'd2, 0, 5, 0, 0, 1, 9};
    vt[12] = '{4'd3, 5, 9, 0, 5, 1, 9};
    vt[13] = '{4'd1, 7, 7, 7, 0, 0, 2};

    reset = 1'b1; run = 1'b1; start = 1'b0;
    opcode = '0; operand_a = '0; operand_b = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_rem", int'(remainder), 0);
    chk("rst_flags", int'(flags), 0);
    @(negedge clock); reset = 1'b0;

    // Fixed vectors checked against hand-derived expectations
    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      opcode = vt[i].op; operand_a = W'(vt[i].a);
      operand_b = W'(vt[i].b); start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0; operand_a = W'($urandom); operand_b = W'($urandom);
      t = 0;
      while (!done && t < 600) begin @(posedge clock); #1; t++; end
      chk($sformatf("vec%0d_lat", i), t, vt[i].lat);
      chk($sformatf("vec%0d_res", i), int'(result), vt[i].res);
      chk($sformatf("vec%0d_rem", i), int'(remainder), vt[i].rem);
      chk($sformatf("vec%0d_flags", i), int'(flags), vt[i].flg);
      @(posedge clock); #1;
    end

    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(1, 4);
      a = $urandom_range(0, MASK);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, MASK);
      run_op(4'(op), a, b, $sformatf("rnd%0d", i), 0, 0, 1'b0);
    end
    for (int i = 0; i < 4; i++)
      run_op(4'(ill[$urandom_range(0, 9)]), $urandom_range(0, MASK),
             $urandom_range(0, MASK), $sformatf("ill%0d", i), 0, 0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 7)) @(negedge clock);
      run_op(4'd5, $urandom_range(0, MASK), 10,
             $sformatf("rand%0d", i), 0, 0, 1'b0);
      chk($sformatf("rand%0d_range", i), int'(result < 10), 1);
    end
    run_op(4'd5, 0, 0, "rand_b0", 0, 0, 1'b0);

    run_op(4'd2, 13, 11, "mul_poke", 0, 0, 1'b1);
    run_op(4'd3, 200, 7, "div_stall", 3, 5, 1'b0);

    // done must survive run=0 while sitting in DONE
    @(negedge clock);
    opcode = 4'd2; operand_a = 8'd2; operand_b = 8'd3; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    t = 0;
    while (!done && t < 600) begin @(posedge clock); #1; t++; end
    run = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("frz_done", int'(done), 1);
    chk("frz_res", int'(result), 6);
    run = 1'b1;
    @(posedge clock); #1;
    chk("frz_release", int'(done), 0);

    // Abort a MUL in its fourth RUN cycle
    run_op(4'd2, 13, 11, "pre_abort", 0, 0, 1'b0);
    @(negedge clock);
    opcode = 4'd2; operand_a = 8'd9; operand_b = 8'd7; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_res", int'(result), 0);
    chk("abort_rem", int'(remainder), 0);
    chk("abort_flags", int'(flags), 0);
    t = 0;
    repeat (12) begin @(posedge clock); #1; t += int'(done); end
    @(negedge clock); reset = 1'b0;
    repeat (10) begin @(posedge clock); #1; t += int'(done); end
    chk("abort_nodone", t, 0);
    run_op(4'd2, 3, 5, "post_abort", 0, 0, 1'b0);
    run_op(4'd5, 0, 10, "post_abort_rand", 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_arith_unit.md
MULTICYCLE_ARITH_UNIT -- requirements
Module: multicycle_arith_unit

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits (legal range 4..32).
REQ-002 Parameter: LFSR_SEED, 1, reset value of the random-number LFSR; SHALL be nonzero.
REQ-003 Port: clock  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: run  input  1  global enable; low freezes FSM, datapath registers and LFSR.
REQ-006 Port: start  input  1  request; sampled only in IDLE with run=1.
REQ-007 Port: opcode  input  4  0001 GCD, 0010 MUL, 0011 DIV, 0100 MOD, 0101 RAND; others illegal.
REQ-008 Port: operand_a  input  WIDTH  first operand (unsigned).
REQ-009 Port: operand_b  input  WIDTH  second operand, or upper limit for RAND (unsigned).
REQ-010 Port: busy  output  1  high in RUN and DONE states.
REQ-011 Port: done  output  1  one-cycle completion pulse.
REQ-012 Port: result  output  WIDTH  primary result.
REQ-013 Port: remainder  output  WIDTH  DIV/MOD remainder; 0 for other ops.
REQ-014 Port: flags  output  3  {err, overflow, zero}.

Function
REQ-015 States: IDLE, RUN, DONE.
- IDLE->RUN on an edge with start=1 and run=1; opcode and operands are captured on that edge.
- RUN->DONE when the iteration terminates.
- DONE->IDLE unconditionally after one cycle.
REQ-016 done SHALL be high exactly during the DONE cycle. result, remainder and flags SHALL update on the edge entering DONE and hold until the next DONE.
REQ-017 start while busy SHALL be ignored and not queued; operand/opcode changes after capture SHALL have no effect.
REQ-018 run=0 SHALL hold all state and outputs, including done; execution resumes unchanged when run returns high.
REQ-019 MUL: shift-add, one multiplier bit per RUN cycle, exactly WIDTH RUN cycles.
- result = low WIDTH bits of the 2*WIDTH product.
- overflow = 1 iff the high WIDTH bits are nonzero.
REQ-020 DIV/MOD: restoring shift-subtract, exactly WIDTH RUN cycles.
- DIV: result = quotient, remainder = remainder.
- MOD: result = remainder, remainder = remainder.
REQ-021 DIV/MOD with operand_b=0: one RUN cycle, result = all-ones (DIV) or operand_a (MOD), remainder = operand_a, err = 1.
REQ-022 GCD: subtractive Euclid, larger -= smaller, one step per RUN cycle; terminates when the operands are equal or either is 0.
- result = the nonzero operand, or 0 if both are 0.
- Minimum one RUN cycle.
REQ-023 RAND: WIDTH-bit maximal-length Galois LFSR advances every clock with run=1, whatever the FSM state.
- On accept, the LFSR value is captured and reduced modulo operand_b via the DIV/MOD path (WIDTH RUN cycles); result = value mod operand_b.
- operand_b=0: result = captured value, err = 0, one RUN cycle.
REQ-024 Illegal opcode: one RUN cycle, result = 0, remainder = 0, err = 1.
REQ-025 zero = (result == 0); overflow = 0 for all ops except MUL; err = 0 except per REQ-021 and REQ-024.
REQ-026 Latency: done asserts in the cycle following the (N+1)th edge after the accepting edge, where N = RUN-cycle count; assumes run continuously high.

Reset
REQ-027 Reset SHALL force IDLE immediately: busy=0, done=0, result=0, remainder=0, flags=000, LFSR=LFSR_SEED, all internal registers 0.
REQ-028 Reset mid-operation SHALL abort without a done pulse; the first start after release is accepted normally.

Verification (WIDTH=8)
REQ-029 MUL 13x11 -> result 143, flags 000, done 9 edges after accept; MUL 20x20 -> result 144, overflow=1.
REQ-030 DIV 200/7 -> result 28, remainder 4; MOD 200%7 -> result 4; DIV 200/0 -> result 255, remainder 200, err=1.
REQ-031 GCD(48,18) -> 6; GCD(0,0) -> 0 with zero=1; GCD(0,9) -> 9 after one RUN cycle.
REQ-032 RAND limit 10, issued 20 times at random gaps -> every result < 10; reference-model LFSR match from LFSR_SEED.
REQ-033 start pulsed during a MUL, and run held low for 5 cycles mid-DIV -> second start ignored; DIV result correct, latency extended by exactly 5.
REQ-034 Reset asserted on RUN cycle 4 of MUL -> outputs 0 immediately, no done; a following MUL 3x5 -> 15.
